// File: rtl/jt51_sh_wr.sv
// jt51_sh_wr: write-merge stage feeding the jt51_sh slot ring.
// Recirculates ring_drop into ring_din and substitutes one buffered CPU write
// in its target slot. Owns the slot counter labelling the entry on ring_drop.
// Optional one-deep readback port enabled by defining JT51_SH_RD_EN; without
// it rd_data/rd_valid are tied low and rd_req/rd_slot are ignored.
module jt51_sh_wr #(
  parameter int   width  = 5,
  parameter int   stages = 32,
  parameter logic rstval = 1'b0,
  localparam int  SW     = $clog2(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_done,
  input  logic [width-1:0] ring_drop,
  output logic [width-1:0] ring_din,
  output logic [SW-1:0]    slot,
  output logic             slot_zero,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic [width-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [SW-1:0] LAST = SW'(stages - 1);

  logic [SW-1:0]    pend_slot;
  logic [width-1:0] pend_data;
  logic             wr_slot_ok;
  logic             hit;
  logic             inject;

  // A power-of-two ring covers every encodable slot index, so the range
  // check only exists for other sizes.
  generate
    if (stages == (1 << SW)) begin : g_wr_full
      assign wr_slot_ok = 1'b1;
    end else begin : g_wr_range
      assign wr_slot_ok = (wr_slot <= LAST);
    end
  endgenerate

  // Merge only from the registered pending write, never from wr_data.
  assign hit    = wr_busy && (slot == pend_slot);
  assign inject = cen && hit;

  assign slot_zero = (slot == '0);

  // Ring input: reset fill, pending write in its slot, otherwise pass-through.
  always_comb begin
    ring_din = ring_drop;
    if (rst)
      ring_din = {width{rstval}};
    else if (hit)
      ring_din = pend_data;
  end

  // Slot counter, advancing in lockstep with the ring on cen.
  always_ff @(posedge clk) begin
    if (rst)
      slot <= '0;
    else if (cen)
      slot <= (slot == LAST) ? '0 : slot + 1'b1;
  end

  // Pending write buffer with busy/done handshake; accept needs no cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_busy   <= 1'b0;
      wr_done   <= 1'b0;
      pend_slot <= '0;
      pend_data <= '0;
    end else begin
      wr_done <= inject;
      if (inject) begin
        wr_busy <= 1'b0;
      end else if (wr_req && !wr_busy && wr_slot_ok) begin
        wr_busy   <= 1'b1;
        pend_slot <= wr_slot;
        pend_data <= wr_data;
      end
    end
  end

`ifdef JT51_SH_RD_EN
  logic          rd_pend;
  logic [SW-1:0] rd_pslot;
  logic          rd_slot_ok;
  logic          rd_hit;

  generate
    if (stages == (1 << SW)) begin : g_rd_full
      assign rd_slot_ok = 1'b1;
    end else begin : g_rd_range
      assign rd_slot_ok = (rd_slot <= LAST);
    end
  endgenerate

  assign rd_hit = cen && rd_pend && (slot == rd_pslot);

  // One-deep readback: capture the post-merge ring input when the slot passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_pslot <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) begin
        rd_pend <= 1'b0;
        rd_data <= ring_din;
      end else if (rd_req && !rd_pend && rd_slot_ok) begin
        rd_pend  <= 1'b1;
        rd_pslot <= rd_slot;
      end
    end
  end
`else
  logic unused_rd;

  assign unused_rd = ^{rd_req, rd_slot};
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_jt51_sh_wr.sv
// tb_jt51_sh_wr: directed bench for jt51_sh_wr with a behavioural 32-stage
// ring closing the loop from ring_din back to ring_drop.
module tb_jt51_sh_wr;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       wr_req;
  logic [4:0] wr_slot;
  logic [4:0] wr_data;
  logic       wr_busy;
  logic       wr_done;
  logic [4:0] ring_drop;
  logic [4:0] ring_din;
  logic [4:0] slot;
  logic       slot_zero;
  logic       rd_req;
  logic [4:0] rd_slot;
  logic [4:0] rd_data;
  logic       rd_valid;

  int checks = 0;
  int errors = 0;
  int exp_slot = 0;
  logic [4:0] mem [32];
  logic [4:0] ring [32];

  jt51_sh_wr #(.width(5), .stages(32), .rstval(1'b0)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done),
    .ring_drop(ring_drop), .ring_din(ring_din),
    .slot(slot), .slot_zero(slot_zero),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Behavioural jt51_sh ring
  always @(posedge clk) begin
    if (cen) begin
      ring[0] <= ring_din;
      for (int i = 1; i < 32; i++) ring[i] <= ring[i-1];
    end
  end
  assign ring_drop = ring[31];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // cen toggles shortly after each posedge: every other edge is a cen edge
  initial begin
    cen = 0;
    forever begin
      @(posedge clk);
      #2 cen = ~cen;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk; expected slot follows the rst/cen values seen by the edge
  task automatic clk_step();
    logic c, r;
    c = cen;
    r = rst;
    @(negedge clk);
    if (r) exp_slot = 0;
    else if (c) exp_slot = (exp_slot == 31) ? 0 : exp_slot + 1;
  endtask

  // Step until just after the next cen edge, then check the counter
  task automatic cen_step();
    logic c;
    do begin
      c = cen;
      clk_step();
    end while (!c);
    chk("slot", 32'(slot), 32'(exp_slot));
    chk("slot_zero", 32'(slot_zero), 32'(exp_slot == 0));
  endtask

  // Park at a negedge where slot==s and the coming edge is a cen edge
  task automatic wait_slot(input int s);
    int n;
    n = 0;
    while (!(exp_slot == s && cen) && n < 200) begin
      clk_step();
      n++;
    end
    chk("wait_slot", 32'(exp_slot), 32'(s));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!wr_done && n < 200) begin
      clk_step();
      n++;
    end
    chk("wr_done_seen", 32'(wr_done), 32'd1);
  endtask

  // Compare every ring entry against the expected slot contents
  task automatic check_frame(input int n);
    for (int i = 0; i < n; i++) begin
      cen_step();
      chk($sformatf("ring_drop[%0d]", exp_slot), 32'(ring_drop), 32'(mem[exp_slot]));
    end
  endtask

  task automatic do_write(input int at, input logic [4:0] s, input logic [4:0] d);
    int n;
    wait_slot(at);
    wr_req = 1; wr_slot = s; wr_data = d;
    clk_step();
    wr_req = 0;
    wait_done(n);
    mem[s] = d;
  endtask

  initial begin
    int n;
    rst = 1; wr_req = 0; wr_slot = '0; wr_data = '0; rd_req = 0; rd_slot = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset: clear the ring over more than 32 cen edges
    repeat (70) clk_step();
    chk("rst_ring_din", 32'(ring_din), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_busy", 32'(wr_busy), 32'h0);
    chk("rst_done", 32'(wr_done), 32'h0);
    rst = 0;
    check_frame(32);

    // Single write: slot 5 = 1A accepted at slot 2
    wait_slot(2);
    wr_req = 1; wr_slot = 5'd5; wr_data = 5'h1A;
    clk_step();
    wr_req = 0; wr_data = 5'h00;
    chk("single_busy", 32'(wr_busy), 32'd1);
    chk("single_slot3", 32'(slot), 32'd3);
    chk("passthru", 32'(ring_din), 32'(ring_drop));
    cen_step();
    cen_step();
    chk("single_at5", 32'(slot), 32'd5);
    chk("single_busy5", 32'(wr_busy), 32'd1);
    chk("merge_5", 32'(ring_din), 32'h1A);
    chk("no_done_yet", 32'(wr_done), 32'd0);
    cen_step();
    chk("single_done", 32'(wr_done), 32'd1);
    chk("single_idle", 32'(wr_busy), 32'd0);
    chk("single_slot6", 32'(slot), 32'd6);
    clk_step();
    chk("single_done_1clk", 32'(wr_done), 32'd0);
    mem[5] = 5'h1A;
    check_frame(64);

    // Wrap: slot 1 = 0C accepted at slot 31
    wait_slot(31);
    wr_req = 1; wr_slot = 5'd1; wr_data = 5'h0C;
    clk_step();
    wr_req = 0;
    chk("wrap_busy", 32'(wr_busy), 32'd1);
    cen_step();
    chk("wrap_slot1", 32'(slot), 32'd1);
    chk("wrap_merge", 32'(ring_din), 32'h0C);
    cen_step();
    chk("wrap_done", 32'(wr_done), 32'd1);
    chk("wrap_slot2", 32'(slot), 32'd2);
    mem[1] = 5'h0C;

    // Busy: slot 20 = 15 pending, slot 9 = 03 held requested until accepted
    wait_slot(10);
    wr_req = 1; wr_slot = 5'd20; wr_data = 5'h15;
    clk_step();
    wr_slot = 5'd9; wr_data = 5'h03;
    wait_done(n);
    chk("busy_first_slot", 32'(slot), 32'd21);
    chk("busy_low_at_done", 32'(wr_busy), 32'd0);
    mem[20] = 5'h15;
    clk_step();
    wr_req = 0;
    chk("retry_accepted", 32'(wr_busy), 32'd1);
    wait_done(n);
    chk("retry_slot", 32'(slot), 32'd10);
    mem[9] = 5'h03;
    check_frame(64);

    // Abort: rst while busy; no done pulse, ring cleared
    wait_slot(3);
    wr_req = 1; wr_slot = 5'd30; wr_data = 5'h1F;
    clk_step();
    wr_req = 0;
    chk("abort_busy", 32'(wr_busy), 32'd1);
    rst = 1;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      clk_step();
      if (wr_done !== 1'b0) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_busy_clr", 32'(wr_busy), 32'd0);
    chk("abort_ring_din", 32'(ring_din), 32'd0);
    rst = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      clk_step();
      if (wr_done !== 1'b0) n++;
    end
    chk("abort_no_late_done", 32'(n), 32'd0);
    check_frame(32);

`ifdef JT51_SH_RD_EN
    // Readback of slot 7 after it has circulated
    do_write(12, 5'd7, 5'h11);
    clk_step();
    rd_req = 1; rd_slot = 5'd7;
    clk_step();
    rd_req = 0; rd_slot = 5'd2;
    n = 0;
    while (!rd_valid && n < 200) begin
      clk_step();
      n++;
    end
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_slot_seen", 32'(slot), 32'd8);
    chk("rd_data", 32'(rd_data), 32'h11);
    clk_step();
    chk("rd_valid_1clk", 32'(rd_valid), 32'd0);
`else
    do_write(12, 5'd7, 5'h11);
    rd_req = 1; rd_slot = 5'd7;
    n = 0;
    for (int i = 0; i < 140; i++) begin
      clk_step();
      if (rd_valid !== 1'b0 || rd_data !== 5'd0) n++;
    end
    rd_req = 0;
    chk("rd_tied_low", 32'(n), 32'd0);
`endif
    check_frame(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
